// File: rtl/video_timing_monitor_if.sv
// video_timing_monitor_if: raw HS/VS/DE/pixel video stream between a source (master) and a monitor (slave)
// vid_hs/vid_vs active-low syncs, vid_de active-high data enable, vid_d pixel {R,G,B}
interface video_timing_monitor_if;
  logic        vid_hs;
  logic        vid_vs;
  logic        vid_de;
  logic [23:0] vid_d;
  modport master (output vid_hs, vid_vs, vid_de, vid_d);
  modport slave  (input  vid_hs, vid_vs, vid_de, vid_d);
endinterface

// File: rtl/video_timing_monitor.sv
// video_timing_monitor: measures HS/VS/DE stream timing, declares lock on identical frames, captures a probe pixel
// clk/reset: pixel clock, sync active-high reset; vid: video stream (slave)
// probe_x/probe_y: active-area capture coordinate; h_total/h_active/v_total/v_active: latest frame snapshot
// locked/frame_done/timing_err: lock status and pulses; probe_pixel/probe_valid: captured pixel and update pulse
module video_timing_monitor #(
  parameter int CNT_W = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  video_timing_monitor_if.slave vid,
  input  logic [CNT_W-1:0]     probe_x,
  input  logic [CNT_W-1:0]     probe_y,
  output logic [CNT_W-1:0]     h_total,
  output logic [CNT_W-1:0]     h_active,
  output logic [CNT_W-1:0]     v_total,
  output logic [CNT_W-1:0]     v_active,
  output logic                 locked,
  output logic                 frame_done,
  output logic                 timing_err,
  output logic [23:0]          probe_pixel,
  output logic                 probe_valid
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam int M_W = $clog2(LOCK_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, SEARCH, CHECK, LOCKED} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (v == MAX) ? v : v + CNT_W'(en);
  endfunction
  function automatic logic ovf(input logic [CNT_W-1:0] v, input logic en);
    return en && v == MAX;
  endfunction
  logic hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic hf_q, hf_d, vf_q, vf_d, de2_q, de2_d;
  logic [23:0] d1_q, d1_d, d2_q, d2_d, probe_pixel_q, probe_pixel_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, decnt_q, decnt_d, href_q, href_d, dref_q, dref_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d, acnt_q, acnt_d, px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d, v_total_q, v_total_d, v_active_q, v_active_d;
  logic [CNT_W-1:0] href_l, dref_l, lcnt_l, acnt_l, px_e, py_e;
  logic bad_q, bad_d, bad_l, line_act, first_line, eval, same, ok, hit;
  logic frame_done_q, frame_done_d, timing_err_q, timing_err_d, probe_valid_q, probe_valid_d;
  logic [M_W-1:0] match_q, match_d, match_inc;
  state_t state_q, state_d;
  always_comb begin
    hs1_d = vid.vid_hs;
    vs1_d = vid.vid_vs;
    de1_d = vid.vid_de;
    d1_d = vid.vid_d;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    hf_d = hs2_q & ~hs1_q;
    vf_d = vs2_q & ~vs1_q;
    de2_d = de1_q;
    d2_d = d1_q;
    // Line close (hf_q) is folded into the *_l values first so a coincident frame close sees the finished line
    line_act = decnt_q != '0;
    first_line = lcnt_q == '0;
    href_l = (hf_q && first_line) ? hcnt_q : href_q;
    dref_l = (hf_q && line_act && dref_q == '0) ? decnt_q : dref_q;
    lcnt_l = sat_inc(lcnt_q, hf_q);
    acnt_l = sat_inc(acnt_q, hf_q && line_act);
    bad_l = bad_q || ovf(lcnt_q, hf_q) || ovf(acnt_q, hf_q && line_act)
          || (!hf_q && (ovf(hcnt_q, 1'b1) || ovf(decnt_q, de2_q)))
          || (hf_q && !first_line && hcnt_q != href_q)
          || (hf_q && line_act && dref_q != '0 && decnt_q != dref_q);
    hcnt_d = hf_q ? CNT_W'(1) : sat_inc(hcnt_q, 1'b1);
    decnt_d = hf_q ? CNT_W'(de2_q) : sat_inc(decnt_q, de2_q);
    href_d = vf_q ? '0 : href_l;
    dref_d = vf_q ? '0 : dref_l;
    lcnt_d = vf_q ? '0 : lcnt_l;
    acnt_d = vf_q ? '0 : acnt_l;
    bad_d = !vf_q && bad_l;
    // The VS edge that leaves IDLE only arms measurement; its partial frame is never evaluated
    eval = vf_q && state_q != IDLE;
    same = {href_l, dref_l, lcnt_l, acnt_l} == {h_total_q, h_active_q, v_total_q, v_active_q};
    ok = !bad_l && same;
    match_inc = match_q + M_W'(1);
    h_total_d = eval ? href_l : h_total_q;
    h_active_d = eval ? dref_l : h_active_q;
    v_total_d = eval ? lcnt_l : v_total_q;
    v_active_d = eval ? acnt_l : v_active_q;
    frame_done_d = eval;
    timing_err_d = eval && state_q == LOCKED && !ok;
    state_d = !vf_q ? state_q :
              state_q == IDLE ? SEARCH :
              bad_l ? SEARCH :
              state_q == SEARCH ? CHECK :
              ok ? ((state_q == LOCKED || int'(match_inc) >= LOCK_FRAMES) ? LOCKED : CHECK) :
              state_q == LOCKED ? SEARCH : CHECK;
    match_d = !eval ? match_q : (state_q == CHECK && ok) ? match_inc : M_W'(1);
    px_e = hf_q ? '0 : px_q;
    py_e = vf_q ? '0 : sat_inc(py_q, hf_q && line_act);
    hit = state_q != IDLE && de2_q && px_e == probe_x && py_e == probe_y;
    px_d = sat_inc(px_e, de2_q);
    py_d = py_e;
    probe_pixel_d = hit ? d2_q : probe_pixel_q;
    probe_valid_d = hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {hs1_q, vs1_q, hs2_q, vs2_q} <= 4'hF;
      {de1_q, hf_q, vf_q, de2_q, bad_q} <= '0;
      {d1_q, d2_q, probe_pixel_q} <= '0;
      {hcnt_q, decnt_q, href_q, dref_q, lcnt_q, acnt_q, px_q, py_q} <= '0;
      {h_total_q, h_active_q, v_total_q, v_active_q} <= '0;
      {frame_done_q, timing_err_q, probe_valid_q} <= '0;
      match_q <= '0;
      state_q <= IDLE;
    end else begin
      {hs1_q, vs1_q, hs2_q, vs2_q} <= {hs1_d, vs1_d, hs2_d, vs2_d};
      {de1_q, hf_q, vf_q, de2_q, bad_q} <= {de1_d, hf_d, vf_d, de2_d, bad_d};
      {d1_q, d2_q, probe_pixel_q} <= {d1_d, d2_d, probe_pixel_d};
      {hcnt_q, decnt_q, href_q, dref_q} <= {hcnt_d, decnt_d, href_d, dref_d};
      {lcnt_q, acnt_q, px_q, py_q} <= {lcnt_d, acnt_d, px_d, py_d};
      {h_total_q, h_active_q, v_total_q, v_active_q} <= {h_total_d, h_active_d, v_total_d, v_active_d};
      {frame_done_q, timing_err_q, probe_valid_q} <= {frame_done_d, timing_err_d, probe_valid_d};
      match_q <= match_d;
      state_q <= state_d;
    end
  end
  assign h_total = h_total_q;
  assign h_active = h_active_q;
  assign v_total = v_total_q;
  assign v_active = v_active_q;
  assign locked = state_q == LOCKED;
  assign frame_done = frame_done_q;
  assign timing_err = timing_err_q;
  assign probe_pixel = probe_pixel_q;
  assign probe_valid = probe_valid_q;
endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor: directed scenario tests for video_timing_monitor
`timescale 1ns/1ps
module tb_video_timing_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  video_timing_monitor_if vif();
  logic [11:0] probe_x, probe_y, h_total, h_active, v_total, v_active;
  logic locked, frame_done, timing_err, probe_valid;
  logic [23:0] probe_pixel, probe_pixel2;
  logic [4:0] p2 = 5'd31;
  logic [4:0] h_total2, h_active2, v_total2, v_active2;
  logic locked2, frame_done2, timing_err2, probe_valid2;
  int checks = 0;
  int errors = 0;
  video_timing_monitor dut (
    .clk(clk), .reset(reset), .vid(vif.slave), .probe_x(probe_x), .probe_y(probe_y),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .frame_done(frame_done), .timing_err(timing_err),
    .probe_pixel(probe_pixel), .probe_valid(probe_valid));
  video_timing_monitor #(.CNT_W(5)) dut2 (
    .clk(clk), .reset(reset), .vid(vif.slave), .probe_x(p2), .probe_y(p2),
    .h_total(h_total2), .h_active(h_active2), .v_total(v_total2), .v_active(v_active2),
    .locked(locked2), .frame_done(frame_done2), .timing_err(timing_err2),
    .probe_pixel(probe_pixel2), .probe_valid(probe_valid2));
  int cyc = 0, vs_cyc = 0, tgt_cyc = 0;
  logic vs_last = 1'b1;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (vs_last && !vif.vid_vs) vs_cyc = cyc;
    if (vif.vid_de && vif.vid_d == 24'h0203A5) tgt_cyc = cyc;
    vs_last = vif.vid_vs;
  end
  int fd_cnt = 0, te_cnt = 0, pv_cnt = 0, fd_delta = -1, lock_delta = -1, pv_delta = -1;
  int lock2_cnt = 0, fd2_cnt = 0, misc2 = 0;
  logic [23:0] pv_pix = '0;
  logic lock_last = 1'b0;
  always @(negedge clk) begin
    if (frame_done) begin fd_cnt++; fd_delta = cyc - vs_cyc; end
    if (timing_err) te_cnt++;
    if (probe_valid) begin pv_cnt++; pv_pix = probe_pixel; pv_delta = cyc - tgt_cyc; end
    if (locked && !lock_last) lock_delta = cyc - vs_cyc;
    lock_last = locked;
    if (locked2) lock2_cnt++;
    if (frame_done2) fd2_cnt++;
    if (timing_err2 || probe_valid2 || probe_pixel2 != 0 || h_active2 != 0 || v_total2 != 0 || v_active2 != 0) misc2++;
  end
  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vif.vid_hs = 1'b1; vif.vid_vs = 1'b1; vif.vid_de = 1'b0; vif.vid_d = '0;
    end
  endtask
  // Frame of 10 lines: HS low cols 0-1, DE cols 4-15 on lines 2-7, VS low for one line starting at vs_off
  task automatic gen_frame(input int ht, input int nl, input int long_line, input int vs_off);
    for (int l = 0; l < nl; l++)
      for (int c = 0; c < ht + ((l == long_line) ? 1 : 0); c++) begin
        @(negedge clk);
        vif.vid_hs = (c >= 2);
        vif.vid_vs = !((l == 0 && c >= vs_off) || (l == 1 && c < vs_off));
        vif.vid_de = (l >= 2 && l < 8 && c >= 4 && c < 16);
        vif.vid_d = vif.vid_de ? {8'(l - 2), 8'(c - 4), 8'hA5} : 24'd0;
      end
    #1;
  endtask
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle(2);
    reset = 1'b0;
    drive_idle(2);
    #1;
  endtask
  task automatic test_reset();
    drive_idle(3);
    #1;
    checks++; if (locked !== 1'b0 || frame_done !== 1'b0 || timing_err !== 1'b0) begin errors++; $display("FAIL reset_status: locked=%0b fd=%0b te=%0b expected 0", locked, frame_done, timing_err); end
    checks++; if ({h_total, h_active, v_total, v_active} !== 48'd0) begin errors++; $display("FAIL reset_meas: got %0d/%0d/%0d/%0d expected 0", h_total, h_active, v_total, v_active); end
    checks++; if (probe_valid !== 1'b0 || probe_pixel !== 24'd0) begin errors++; $display("FAIL reset_probe: pv=%0b pix=%h expected 0", probe_valid, probe_pixel); end
  endtask
  task automatic test_lock();
    int fd0;
    @(negedge clk);
    reset = 1'b0;
    drive_idle(3);
    #1;
    fd0 = fd_cnt;
    gen_frame(20, 10, -1, 4);
    checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL lock_first_vs: frame_done count %0d expected 0", fd_cnt - fd0); end
    gen_frame(20, 10, -1, 4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%0b expected 0", locked); end
    gen_frame(20, 10, -1, 4);
    gen_frame(20, 10, -1, 4);
    checks++; if (fd_cnt - fd0 !== 3) begin errors++; $display("FAIL lock_fd_count: got %0d expected 3", fd_cnt - fd0); end
    checks++; if (fd_delta !== 2) begin errors++; $display("FAIL lock_fd_latency: got %0d expected 2", fd_delta); end
    checks++; if (lock_delta !== 2) begin errors++; $display("FAIL lock_latency: got %0d expected 2", lock_delta); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_state: locked=%0b expected 1", locked); end
    checks++; if ({h_total, h_active, v_total, v_active} !== {12'd20, 12'd12, 12'd10, 12'd6}) begin errors++; $display("FAIL lock_meas: got %0d/%0d/%0d/%0d expected 20/12/10/6", h_total, h_active, v_total, v_active); end
  endtask
  task automatic test_timing_err();
    int te0;
    te0 = te_cnt;
    gen_frame(20, 10, 5, 4);
    gen_frame(20, 10, -1, 4);
    checks++; if (te_cnt - te0 !== 1) begin errors++; $display("FAIL err_pulse: timing_err count %0d expected 1", te_cnt - te0); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_unlock: locked=%0b expected 0", locked); end
    gen_frame(20, 10, -1, 4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_relock_early: locked=%0b expected 0", locked); end
    gen_frame(20, 10, -1, 4);
    checks++; if (locked !== 1'b1 || te_cnt - te0 !== 1) begin errors++; $display("FAIL err_relock: locked=%0b te=%0d expected 1/1", locked, te_cnt - te0); end
  endtask
  task automatic test_probe();
    int pv0;
    probe_x = 12'd3;
    probe_y = 12'd2;
    pv0 = pv_cnt;
    gen_frame(20, 10, -1, 4);
    gen_frame(20, 10, -1, 4);
    checks++; if (pv_cnt - pv0 !== 2) begin errors++; $display("FAIL probe_count: got %0d expected 2", pv_cnt - pv0); end
    checks++; if (pv_pix !== 24'h0203A5) begin errors++; $display("FAIL probe_pixel: got %h expected 0203a5", pv_pix); end
    checks++; if (pv_delta !== 2) begin errors++; $display("FAIL probe_latency: got %0d expected 2", pv_delta); end
    probe_x = 12'd12;
    pv0 = pv_cnt;
    gen_frame(20, 10, -1, 4);
    gen_frame(20, 10, -1, 4);
    checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL probe_out_of_range: got %0d expected 0", pv_cnt - pv0); end
    probe_x = 12'd100;
    probe_y = 12'd100;
  endtask
  task automatic test_mid_reset();
    int fd0;
    gen_frame(20, 5, -1, 4);
    @(negedge clk);
    reset = 1'b1;
    vif.vid_hs = 1'b1; vif.vid_vs = 1'b1; vif.vid_de = 1'b0; vif.vid_d = '0;
    @(negedge clk);
    #1;
    checks++; if (locked !== 1'b0 || {h_total, v_active} !== 24'd0 || probe_pixel !== 24'd0) begin errors++; $display("FAIL midreset_outputs: locked=%0b h=%0d va=%0d pix=%h expected 0", locked, h_total, v_active, probe_pixel); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    fd0 = fd_cnt;
    gen_frame(20, 10, -1, 4);
    checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL midreset_first_vs: frame_done count %0d expected 0", fd_cnt - fd0); end
    gen_frame(20, 10, -1, 4);
    gen_frame(20, 10, -1, 4);
    checks++; if (locked !== 1'b1 || fd_cnt - fd0 !== 2) begin errors++; $display("FAIL midreset_relock: locked=%0b fd=%0d expected 1/2", locked, fd_cnt - fd0); end
  endtask
  task automatic test_simultaneous();
    int fd0;
    apply_reset();
    fd0 = fd_cnt;
    for (int f = 0; f < 3; f++) gen_frame(20, 10, -1, 0);
    checks++; if (v_total !== 12'd10 || h_total !== 12'd20) begin errors++; $display("FAIL simul_meas: v_total=%0d h_total=%0d expected 10/20", v_total, h_total); end
    checks++; if (locked !== 1'b1 || fd_cnt - fd0 !== 2) begin errors++; $display("FAIL simul_lock: locked=%0b fd=%0d expected 1/2", locked, fd_cnt - fd0); end
  endtask
  task automatic test_overflow();
    int l0, f0;
    apply_reset();
    l0 = lock2_cnt;
    f0 = fd2_cnt;
    for (int f = 0; f < 4; f++) gen_frame(40, 10, -1, 4);
    checks++; if (lock2_cnt - l0 !== 0 || locked2 !== 1'b0) begin errors++; $display("FAIL ovf_never_lock: locked cycles %0d expected 0", lock2_cnt - l0); end
    checks++; if (h_total2 !== 5'd31) begin errors++; $display("FAIL ovf_h_total: got %0d expected 31", h_total2); end
    checks++; if (fd2_cnt - f0 !== 3) begin errors++; $display("FAIL ovf_fd_count: got %0d expected 3", fd2_cnt - f0); end
  endtask
  initial begin
    vif.vid_hs = 1'b1; vif.vid_vs = 1'b1; vif.vid_de = 1'b0; vif.vid_d = '0;
    probe_x = 12'd100;
    probe_y = 12'd100;
    test_reset();
    test_lock();
    test_timing_err();
    test_probe();
    test_mid_reset();
    test_simultaneous();
    test_overflow();
    drive_idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_monitor.md
# video_timing_monitor

Receive-side checker for the HDMI video path. It samples a raw HS/VS/DE/pixel stream (the format signal_gen produces), measures horizontal and vertical timing, and declares lock after a configurable number of identical consecutive frames. It also captures the pixel at a programmable active-area coordinate. It sits on the loopback/capture side of the pipeline, driving status to switch/LED logic and bench checkers.

## Interface
- CNT_W, 12: width of all timing counters and coordinates.
- LOCK_FRAMES, 2: consecutive identical complete frames required for lock (≥2).

Ports:
- clk, in, 1: pixel clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- vid_hs, in, 1: horizontal sync, active-low.
- vid_vs, in, 1: vertical sync, active-low.
- vid_de, in, 1: data enable, active-high.
- vid_d, in, 24: pixel {R,G,B}.
- probe_x, in, CNT_W: active-pixel column to capture (0-based).
- probe_y, in, CNT_W: active-line row to capture (0-based).
- h_total, out, CNT_W: clocks per line.
- h_active, out, CNT_W: DE-high clocks per active line.
- v_total, out, CNT_W: lines per frame.
- v_active, out, CNT_W: lines containing ≥1 DE-high clock.
- locked, out, 1: timing stable.
- frame_done, out, 1: one-cycle pulse when a complete frame is evaluated.
- timing_err, out, 1: one-cycle pulse when lock is lost.
- probe_pixel, out, 24: last captured pixel.
- probe_valid, out, 1: one-cycle pulse when probe_pixel updates.

## Operation
- All four video inputs are registered once (stage S1). Edges are detected from S1 against its previous value.
- Line start: HS falling edge. Frame start: VS falling edge.
- Per line:
  - hcnt counts clocks between HS falling edges.
  - decnt counts DE-high clocks.
  - A line is active if decnt > 0.
- Line consistency:
  - The first line's hcnt in a frame is the frame reference.
  - Any later line with a different hcnt sets frame_bad.
  - Any active line with a different decnt from the first active line also sets frame_bad.
- Per frame: lcnt counts HS falling edges, and acnt counts active lines.
- All counters saturate at 2^CNT_W−1. Saturation sets frame_bad.
- FSM states: IDLE, SEARCH, CHECK, LOCKED. Transitions on a VS falling edge:
  - IDLE → SEARCH. This edge only arms measurement; the partial frame is discarded and frame_done is not pulsed.
  - SEARCH: the frame is stored as the snapshot. If frame_bad, stay in SEARCH; else go to CHECK with match_cnt=1.
  - CHECK: if the frame is good and equals the snapshot, match_cnt+1; reaching LOCK_FRAMES moves to LOCKED. Otherwise store the new snapshot; match_cnt=1 if the frame is good, else return to SEARCH.
  - LOCKED: a good, equal frame stays LOCKED. Any mismatch or frame_bad → SEARCH, pulse timing_err, store the new snapshot.
- Outputs:
  - h_total/h_active/v_total/v_active show the snapshot of the latest evaluated frame, updated at every evaluation (valid or not).
  - locked = (state==LOCKED).
- Probe:
  - px counts DE-high clocks within a line (reset at HS fall).
  - py counts active lines within a frame (reset at VS fall).
  - When S1 DE=1, px==probe_x and py==probe_y, S1 pixel → probe_pixel and probe_valid pulses.
  - The probe works in every state except IDLE.
  - Out-of-range probe coordinates never capture.
- Simultaneous HS and VS falling edges: the line close is processed first, then the frame close, in the same cycle.
- Reset (any time, including mid-frame): state IDLE; all counters, match_cnt and snapshot cleared; all outputs 0.

## Timing
- Inputs sampled at edge N appear in S1 after N.
- For a VS input fall sampled at edge N:
  - frame_done and the measurement outputs are updated after edge N+2.
  - locked and timing_err change after edge N+2.
- For a target pixel sampled at edge N: probe_pixel and probe_valid are valid after edge N+2; probe_valid lasts exactly 1 cycle.
- No throughput limit: one sample per clock, and no back-pressure.

## Test plan
- Reset, then stream 4 frames (h_total=20, HS low 2, DE 12 clocks/line, v_total=10, VS low 1 line, 6 active lines). Required: no frame_done at VS edge #1; locked rises 2 cycles after VS edge #3; outputs read 20/12/10/6.
- After lock, lengthen one line of a frame to 21 clocks. Required: at that frame's end, one timing_err pulse, locked=0, state SEARCH; relock after 2 more clean frames.
- probe_x=3, probe_y=2, pixel value = {line,col,8'hA5}. Required: exactly one probe_valid per frame, with probe_pixel={8'd2,8'd3,8'hA5}. With probe_x=12, required: no probe_valid.
- Assert reset mid-frame while locked. Required: all outputs 0 on the next cycle; the first VS edge after release produces no frame_done.
- Apply the HS and VS falling edges in the same cycle, across 3 frames. Required: v_total=10 and lock is achieved (the line is closed before the frame).
- CNT_W=5 with h_total=40. Required: frame_bad set, never locked, h_total reads 31.
